// File: rtl/ecc_pkg.sv
// Shared ECC types and constants for the point-add arbiter slice.
package ecc_pkg;

    localparam int unsigned W = 255;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

    // Projective identity point (0 : 1 : 1)
    localparam logic [W-1:0] ID_X = '0;
    localparam logic [W-1:0] ID_Y = W'(1);
    localparam logic [W-1:0] ID_Z = W'(1);

    function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/point_add_arbiter_if.sv
// Requester-side bus of the point-add arbiter: per-requester operands/handshake and shared result.
interface point_add_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = ecc_pkg::W
);
    logic [NREQ-1:0]         i_req;
    logic [NREQ-1:0]         i_dbl;
    logic [NREQ-1:0][W-1:0]  i_x1;
    logic [NREQ-1:0][W-1:0]  i_y1;
    logic [NREQ-1:0][W-1:0]  i_z1;
    logic [NREQ-1:0][W-1:0]  i_x2;
    logic [NREQ-1:0][W-1:0]  i_y2;
    logic [NREQ-1:0][W-1:0]  i_z2;
    logic [NREQ-1:0]         o_ack;
    logic [NREQ-1:0]         o_done;
    logic [W-1:0]            o_x3;
    logic [W-1:0]            o_y3;
    logic [W-1:0]            o_z3;

    modport master (
        output i_req, i_dbl, i_x1, i_y1, i_z1, i_x2, i_y2, i_z2,
        input  o_ack, o_done, o_x3, o_y3, o_z3
    );

    modport slave (
        input  i_req, i_dbl, i_x1, i_y1, i_z1, i_x2, i_y2, i_z2,
        output o_ack, o_done, o_x3, o_y3, o_z3
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap-around.
module rr_pick
    import ecc_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);
    logic [IW-1:0] idx;

    always_comb begin
        grant_idx = '0;
        idx       = '0;
        any       = |req;
        // Scan from the farthest offset down so the nearest one to ptr wins.
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx = IW'(wrap_add(32'(ptr), unsigned'(i), NREQ));
            if (req[idx]) grant_idx = idx;
        end
    end

endmodule

// File: rtl/point_add_arbiter.sv
// Round-robin arbiter sharing one multi-cycle Edwards point-add core between NREQ requesters.
module point_add_arbiter
    import ecc_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    point_add_arbiter_if.slave   bus,
    output logic                 o_busy,
    output logic                 o_err,
    output logic                 o_pa_start,
    output logic                 o_pa_doubling,
    output logic [W-1:0]         o_pa_x1,
    output logic [W-1:0]         o_pa_y1,
    output logic [W-1:0]         o_pa_z1,
    output logic [W-1:0]         o_pa_x2,
    output logic [W-1:0]         o_pa_y2,
    output logic [W-1:0]         o_pa_z2,
    input  logic                 i_pa_finished,
    input  logic [W-1:0]         i_pa_x3,
    input  logic [W-1:0]         i_pa_y3,
    input  logic [W-1:0]         i_pa_z3
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_idx;
    logic            any_req;
    logic            err_q, err_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] ack;
    logic            cap, res_load;

    logic            pa_dbl_q;
    logic [W-1:0]    pa_x1_q, pa_y1_q, pa_z1_q, pa_x2_q, pa_y2_q, pa_z2_q;
    logic [W-1:0]    x3_q, y3_q, z3_q;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req       (bus.i_req),
        .ptr       (rr_ptr_q),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q;
        done_d   = '0;
        cap      = 1'b0;
        res_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    cap      = 1'b1;
                    owner_d  = grant_idx;
                    rr_ptr_d = IW'(wrap_add(32'(grant_idx), 1, NREQ));
                    state_d  = ISSUE;
                end
                if (i_pa_finished) err_d = 1'b1;
            end
            ISSUE: begin
                // A finish here cannot belong to the op being issued; flag it and carry on.
                if (i_pa_finished) err_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (i_pa_finished) begin
                    res_load        = 1'b1;
                    done_d[owner_q] = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack = '0;
        if (state_q == ISSUE) ack[owner_q] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
            done_q   <= '0;
            pa_dbl_q <= 1'b0;
            pa_x1_q  <= '0;
            pa_y1_q  <= '0;
            pa_z1_q  <= '0;
            pa_x2_q  <= '0;
            pa_y2_q  <= '0;
            pa_z2_q  <= '0;
            x3_q     <= ID_X;
            y3_q     <= ID_Y;
            z3_q     <= ID_Z;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            done_q   <= done_d;
            if (cap) begin
                pa_dbl_q <= bus.i_dbl[grant_idx];
                pa_x1_q  <= bus.i_x1[grant_idx];
                pa_y1_q  <= bus.i_y1[grant_idx];
                pa_z1_q  <= bus.i_z1[grant_idx];
                pa_x2_q  <= bus.i_x2[grant_idx];
                pa_y2_q  <= bus.i_y2[grant_idx];
                pa_z2_q  <= bus.i_z2[grant_idx];
            end
            if (res_load) begin
                x3_q <= i_pa_x3;
                y3_q <= i_pa_y3;
                z3_q <= i_pa_z3;
            end
        end
    end

    assign o_busy        = (state_q != IDLE);
    assign o_err         = err_q;
    assign o_pa_start    = (state_q == ISSUE);
    assign o_pa_doubling = pa_dbl_q;
    assign o_pa_x1       = pa_x1_q;
    assign o_pa_y1       = pa_y1_q;
    assign o_pa_z1       = pa_z1_q;
    assign o_pa_x2       = pa_x2_q;
    assign o_pa_y2       = pa_y2_q;
    assign o_pa_z2       = pa_z2_q;
    assign bus.o_ack     = ack;
    assign bus.o_done    = done_q;
    assign bus.o_x3      = x3_q;
    assign bus.o_y3      = y3_q;
    assign bus.o_z3      = z3_q;

endmodule

// File: tb/tb_point_add_arbiter.sv
// Directed bench for point_add_arbiter with a fixed-latency core model (x3=x1+x2, y3=y1, z3=z2).
module tb_point_add_arbiter;
    import ecc_pkg::*;

    localparam int unsigned NREQ = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         busy, err, pa_start, pa_dbl;
    logic [W-1:0] pa_x1, pa_y1, pa_z1, pa_x2, pa_y2, pa_z2;
    logic         pa_fin;
    logic [W-1:0] m_x3, m_y3, m_z3;
    logic         m_fin;
    logic         spur;
    int           m_cnt;

    int total = 0;
    int bad   = 0;

    point_add_arbiter_if #(.NREQ(NREQ)) bus ();

    point_add_arbiter #(.NREQ(NREQ)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .bus           (bus),
        .o_busy        (busy),
        .o_err         (err),
        .o_pa_start    (pa_start),
        .o_pa_doubling (pa_dbl),
        .o_pa_x1       (pa_x1),
        .o_pa_y1       (pa_y1),
        .o_pa_z1       (pa_z1),
        .o_pa_x2       (pa_x2),
        .o_pa_y2       (pa_y2),
        .o_pa_z2       (pa_z2),
        .i_pa_finished (pa_fin),
        .i_pa_x3       (m_x3),
        .i_pa_y3       (m_y3),
        .i_pa_z3       (m_z3)
    );

    always #5 clk = ~clk;

    // Core model: finish is seen 5 edges after start is seen.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_fin <= 1'b0;
            m_x3  <= '0;
            m_y3  <= '0;
            m_z3  <= '0;
        end else begin
            m_fin <= (m_cnt == 1);
            if (pa_start) begin
                m_cnt <= 4;
                m_x3  <= pa_x1 + pa_x2;
                m_y3  <= pa_y1;
                m_z3  <= pa_z2;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign pa_fin = m_fin | spur;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.i_req = '0;
        bus.i_dbl = '0;
        bus.i_x1  = '0;
        bus.i_y1  = '0;
        bus.i_z1  = '0;
        bus.i_x2  = '0;
        bus.i_y2  = '0;
        bus.i_z2  = '0;
        spur      = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_until_done(input int budget, output int n, output logic [NREQ-1:0] d);
        n = 0;
        d = '0;
        while (n < budget) begin
            tick();
            n++;
            if (bus.o_done != '0) begin
                d = bus.o_done;
                break;
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        total++;
        if (busy !== 1'b0 || err !== 1'b0 || pa_start !== 1'b0 || bus.o_ack !== 2'b00
            || bus.o_done !== 2'b00) begin
            bad++;
            $display("FAIL reset_ctrl got busy=%b err=%b start=%b ack=%b done=%b want all 0",
                     busy, err, pa_start, bus.o_ack, bus.o_done);
        end
        total++;
        if (bus.o_x3 !== W'(0) || bus.o_y3 !== W'(1) || bus.o_z3 !== W'(1)) begin
            bad++;
            $display("FAIL reset_result got x3=%0h y3=%0h z3=%0h want 0/1/1",
                     bus.o_x3, bus.o_y3, bus.o_z3);
        end
    endtask

    task automatic test_single;
        int done_cyc, starts;
        logic saw1, busy_d;
        logic [W-1:0] x3s, y3s, z3s;
        do_reset();
        bus.i_x1[0] = W'(3);
        bus.i_x2[0] = W'(4);
        bus.i_y1[0] = W'(5);
        bus.i_z2[0] = W'(9);
        bus.i_req   = 2'b01;
        tick();
        total++;
        if (bus.o_ack !== 2'b01 || pa_start !== 1'b1) begin
            bad++;
            $display("FAIL single_ack got ack=%b start=%b want 01/1", bus.o_ack, pa_start);
        end
        bus.i_req = '0;
        done_cyc = 0; starts = 0; saw1 = 1'b0; busy_d = 1'b1;
        x3s = '0; y3s = '0; z3s = '0;
        for (int c = 2; c <= 15; c++) begin
            tick();
            if (pa_start) starts++;
            if (bus.o_done[1]) saw1 = 1'b1;
            if (bus.o_done[0] && done_cyc == 0) begin
                done_cyc = c;
                x3s = bus.o_x3; y3s = bus.o_y3; z3s = bus.o_z3;
                busy_d = busy;
            end
        end
        total++;
        if (done_cyc != 7) begin
            bad++;
            $display("FAIL single_done_cycle got %0d want 7", done_cyc);
        end
        total++;
        if (x3s !== W'(7) || y3s !== W'(5) || z3s !== W'(9)) begin
            bad++;
            $display("FAIL single_result got %0h/%0h/%0h want 7/5/9", x3s, y3s, z3s);
        end
        total++;
        if (busy_d !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_at_done got %b want 0", busy_d);
        end
        total++;
        if (starts != 0 || saw1 !== 1'b0) begin
            bad++;
            $display("FAIL single_extra got starts=%0d done1=%b want 0/0", starts, saw1);
        end
    endtask

    task automatic test_round_robin;
        logic [NREQ-1:0] gnt [4];
        logic [NREQ-1:0] down [4];
        logic [W-1:0]    res [4];
        int st_cyc [4];
        int fin_cyc [4];
        int n_st, n_fin, n_done;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            gnt[k] = '0; down[k] = '0; res[k] = '0; st_cyc[k] = 0; fin_cyc[k] = 0;
        end
        n_st = 0; n_fin = 0; n_done = 0;
        bus.i_x1[0] = W'(10); bus.i_x2[0] = W'(1);
        bus.i_x1[1] = W'(20); bus.i_x2[1] = W'(2);
        bus.i_req = 2'b11;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (pa_start && n_st < 4) begin
                gnt[n_st] = bus.o_ack;
                st_cyc[n_st] = c;
                n_st++;
                if (n_st == 4) bus.i_req = '0;
            end
            if (pa_fin && n_fin < 4) begin
                fin_cyc[n_fin] = c;
                n_fin++;
            end
            if (bus.o_done != '0 && n_done < 4) begin
                down[n_done] = bus.o_done;
                res[n_done] = bus.o_x3;
                n_done++;
                if (n_done == 4) break;
            end
        end
        total++;
        if (n_done != 4) begin
            bad++;
            $display("FAIL rr_count got %0d dones want 4", n_done);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (gnt[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10) || down[k] !== gnt[k]
                || res[k] !== ((k % 2 == 0) ? W'(11) : W'(22))) begin
                bad++;
                $display("FAIL rr_op%0d got ack=%b done=%b x3=%0h want %s", k, gnt[k], down[k],
                         res[k], (k % 2 == 0) ? "01/01/b" : "10/10/16");
            end
        end
        for (int k = 1; k < 4; k++) begin
            total++;
            if (st_cyc[k] != fin_cyc[k-1] + 2) begin
                bad++;
                $display("FAIL rr_turnaround%0d got start=%0d want %0d", k, st_cyc[k],
                         fin_cyc[k-1] + 2);
            end
        end
    endtask

    task automatic test_doubling;
        logic [W-1:0] ones;
        logic [NREQ-1:0] d;
        int n;
        ones = '1;
        do_reset();
        bus.i_x1[1] = ones;
        bus.i_x2[1] = W'(2);
        bus.i_dbl   = 2'b10;
        bus.i_req   = 2'b10;
        tick();
        total++;
        if (bus.o_ack !== 2'b10 || pa_dbl !== 1'b1) begin
            bad++;
            $display("FAIL dbl_ctrl got ack=%b dbl=%b want 10/1", bus.o_ack, pa_dbl);
        end
        total++;
        if (pa_x1 !== ones || pa_x2 !== W'(2)) begin
            bad++;
            $display("FAIL dbl_operands got x1=%0h x2=%0h want all-ones/2", pa_x1, pa_x2);
        end
        bus.i_req = '0;
        run_until_done(20, n, d);
        total++;
        if (d !== 2'b10 || bus.o_x3 !== W'(1)) begin
            bad++;
            $display("FAIL dbl_done got done=%b x3=%0h want 10/1", d, bus.o_x3);
        end
    endtask

    task automatic test_spurious;
        logic [NREQ-1:0] d;
        int n;
        do_reset();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || bus.o_done !== 2'b00) begin
            bad++;
            $display("FAIL spur_flag got err=%b busy=%b done=%b want 1/0/00", err, busy,
                     bus.o_done);
        end
        total++;
        if (bus.o_x3 !== W'(0) || bus.o_y3 !== W'(1) || bus.o_z3 !== W'(1)) begin
            bad++;
            $display("FAIL spur_result got %0h/%0h/%0h want 0/1/1", bus.o_x3, bus.o_y3,
                     bus.o_z3);
        end
        bus.i_x1[0] = W'(1);
        bus.i_x2[0] = W'(2);
        bus.i_req   = 2'b01;
        tick();
        bus.i_req = '0;
        run_until_done(20, n, d);
        total++;
        if (d !== 2'b01 || bus.o_x3 !== W'(3) || err !== 1'b1) begin
            bad++;
            $display("FAIL spur_next_op got done=%b x3=%0h err=%b want 01/3/1", d, bus.o_x3,
                     err);
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [NREQ-1:0] d;
        int n, dones;
        do_reset();
        bus.i_x1[0] = W'(1); bus.i_x2[0] = W'(1);
        bus.i_y1[0] = W'(5); bus.i_z2[0] = W'(6);
        bus.i_req = 2'b01;
        tick();
        bus.i_req = '0;
        run_until_done(20, n, d);
        total++;
        if (d !== 2'b01 || bus.o_y3 !== W'(5) || bus.o_z3 !== W'(6)) begin
            bad++;
            $display("FAIL rst_prep got done=%b y3=%0h z3=%0h want 01/5/6", d, bus.o_y3,
                     bus.o_z3);
        end
        bus.i_req = 2'b01;
        tick();
        bus.i_req = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || bus.o_y3 !== W'(1) || bus.o_z3 !== W'(1) || bus.o_x3 !== W'(0))
        begin
            bad++;
            $display("FAIL rst_async got busy=%b x3=%0h y3=%0h z3=%0h want 0/0/1/1", busy,
                     bus.o_x3, bus.o_y3, bus.o_z3);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.o_done != '0) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL rst_no_done got %0d done pulses want 0", dones);
        end
        bus.i_req = 2'b11;
        tick();
        total++;
        if (bus.o_ack !== 2'b01) begin
            bad++;
            $display("FAIL rst_ptr got ack=%b want 01", bus.o_ack);
        end
        bus.i_req = '0;
        run_until_done(20, n, d);
    endtask

    task automatic test_withdrawn;
        int starts, dones;
        logic ack1;
        do_reset();
        bus.i_x1[0] = W'(8);
        bus.i_req = 2'b01;
        tick();
        bus.i_req = '0;
        starts = 0; dones = 0; ack1 = 1'b0;
        for (int c = 2; c <= 20; c++) begin
            tick();
            if (c == 3) bus.i_req = 2'b10;
            if (c == 5) bus.i_req = 2'b00;
            if (pa_start) starts++;
            if (bus.o_ack[1]) ack1 = 1'b1;
            if (bus.o_done != '0) dones++;
        end
        total++;
        if (starts != 0 || ack1 !== 1'b0) begin
            bad++;
            $display("FAIL withdraw_grant got starts=%0d ack1=%b want 0/0", starts, ack1);
        end
        total++;
        if (dones != 1 || busy !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL withdraw_idle got dones=%0d busy=%b err=%b want 1/0/0", dones, busy,
                     err);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_doubling();
        test_spurious();
        test_reset_mid_wait();
        test_withdrawn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/point_add_arbiter.md
# point_add_arbiter

Round-robin arbiter that shares one multi-cycle Edwards point-add/double core (start/finished pulse handshake, 255-bit projective operands) between `NREQ` requesters, e.g. the scalar-multiplication engine and a precompute/coordinate-conversion engine. It latches the winning requester's operands, issues one core operation, and returns the registered result together with a done pulse to the owner. It sits between the requesters and the single `PointAdd` instance in the ECC top level.

## Interface
- `W`, 255: coordinate width.
- `NREQ`, 2: number of requesters, from 2 to 8.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_req`  in  NREQ  per-requester operation request, level.
- `i_dbl`  in  NREQ  per-requester doubling select.
- `i_x1`, `i_y1`, `i_z1`, `i_x2`, `i_y2`, `i_z2`  in  NREQ×W each  per-requester operands, packed with requester k at slice k.
- `o_ack`  out  NREQ  one-cycle pulse: the request has been accepted and the operands have been captured.
- `o_done`  out  NREQ  one-cycle pulse: the result is valid for requester k.
- `o_x3`, `o_y3`, `o_z3`  out  W each  registered result of the last completed operation.
- `o_busy`  out  1  high whenever the state is not IDLE.
- `o_err`  out  1  sticky flag: `i_pa_finished` was seen outside WAIT.
- `o_pa_start`, `o_pa_doubling`  out  1 each  core control.
- `o_pa_x1` … `o_pa_z2`  out  W each  core operands, registered.
- `i_pa_finished`  in  1  core completion pulse.
- `i_pa_x3`, `i_pa_y3`, `i_pa_z3`  in  W each  core result.

## Operation
- The state machine has three states: IDLE, ISSUE and WAIT.
- **IDLE**
  - If any `i_req` is high, pick the winner g: the first requester with `i_req` high, searching from `rr_ptr` upward with wrap-around.
  - Capture g's operands and `i_dbl[g]` into the `o_pa_*` registers, store `owner`=g, and move to ISSUE.
  - Set `rr_ptr` to (g+1) mod NREQ.
- **ISSUE**
  - Lasts exactly one cycle.
  - `o_pa_start`=1 and `o_ack[owner]`=1. Move to WAIT.
- **WAIT**
  - On `i_pa_finished`=1: latch `i_pa_*3` into `o_x3`/`o_y3`/`o_z3`, pulse `o_done[owner]` on the next cycle, and return to IDLE.
- **Requester obligations**
  - Hold `i_req` and the operands stable until `o_ack`.
  - Deassert `i_req` no later than the cycle after `o_ack`, unless a further operation is wanted.
  - Any `i_req` high in IDLE counts as a new request.
- Operands are passed through unmodified; no field arithmetic is done here.
- A request withdrawn before it is granted is simply never granted. No error is raised.
- `i_pa_finished` in IDLE or ISSUE is ignored for data and sets `o_err`. Only reset clears `o_err`.
- At most one core operation is outstanding at any time.
- `o_x3`/`o_y3`/`o_z3` hold their value until the next completion.

## Timing
- **Reset values**
  - State IDLE, `rr_ptr`=0, `owner`=0.
  - All outputs 0, except `o_y3`=1 and `o_z3`=1 (identity point).
- **Reset mid-operation:** all state clears asynchronously. The core shares the same reset, so no done pulse is produced for the aborted operation.
- **Request to start:** a request seen at edge t gives `o_pa_start` and `o_ack` during cycle t+1.
- **Finish to done:** `i_pa_finished` seen at edge u gives `o_done` and valid `o_x3` during cycle u+1. In that cycle the state is IDLE and `o_busy`=0.
- **Back-to-back operations:** a pending request is sampled at edge u+1 and its start occurs in cycle u+2. Turnaround is 2 cycles plus the core latency L.
- **Simultaneous requests:** granted strictly round-robin. No requester waits for more than NREQ−1 other grants.
- **Finish on the ISSUE cycle:** if `i_pa_finished` coincides with the ISSUE cycle, it is treated as an error and the machine still proceeds to WAIT.

## Structure
- **Package `ecc_pkg`** holds:
  - `W`;
  - the enum `arb_state_t` {IDLE, ISSUE, WAIT};
  - the identity-point constants.
- **Sub-module `rr_pick`** (combinational):
  - inputs: `req[NREQ]` and `ptr`;
  - outputs: `grant_idx` and `any`.
- Everything else is flat in `point_add_arbiter`.

## Test plan
The bench uses a core model with fixed latency L=5 whose result is x3=x1+x2, y3=y1, z3=z2.
- **Single request:** requester 0 requests with operands x1=3, x2=4, dbl=0 → `o_ack[0]` in cycle 1, `o_pa_start` once, `o_done[0]` 7 cycles after the request with `o_x3`=7; `o_done[1]` never asserts.
- **Round-robin:** requesters 0 and 1 request simultaneously and continuously for 4 operations → grant order 0,1,0,1; each start comes 2 cycles after the previous finish.
- **Doubling pass-through:** requester 1 only, with dbl=1 and x1=0x7FFF…FF (255 ones) → `o_pa_doubling`=1 and `o_pa_x1` bit-exact with the input.
- **Spurious finish:** pulse `i_pa_finished` while IDLE → `o_err`=1 and stays high; outputs unchanged; the next normal operation still completes correctly.
- **Reset mid-WAIT:** assert `i_rst_n`=0 for one cycle in the third cycle of WAIT → `o_busy`=0, `o_y3`=1, `o_z3`=1 immediately; no `o_done`; `rr_ptr` restarts at requester 0.
- **Withdrawn request:** requester 1 raises `i_req` during requester 0's WAIT and drops it before IDLE → requester 1 receives no ack and the machine stays idle.
